// File: rtl/mod_barrett_param_gen_32b.sv
// Barrett constant generator for a 32-bit modulus.
// Computes K = bit length of M and U = floor(2^(2K) / M) with a bit-serial
// restoring divider, one quotient bit per cycle, behind a start/done handshake.
module mod_barrett_param_gen_32b (
   input  logic        iClk,
   input  logic        iRstN,
   input  logic        iStart,
   input  logic [31:0] iMod,
   output logic        oBusy,
   output logic        oDone,
   output logic        oErr,
   output logic [5:0]  oK,
   output logic [63:0] oU
);

   localparam int unsigned MW = 32;          // modulus width
   localparam int unsigned KW = 6;           // bit-length width
   localparam int unsigned UW = 64;          // quotient / U width
   localparam int unsigned CW = 7;           // step counter width (max 65)
   localparam int unsigned TW = MW + 1;      // partial remainder after shift-in

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_NORM = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [MW-1:0] m_q, m_d;
   logic [MW-1:0] rem_q, rem_d;
   logic [UW-1:0] quo_q, quo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [KW-1:0] k_q, k_d;
   logic          first_q, first_d;
   logic          zwait_q, zwait_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [KW-1:0] ko_q, ko_d;
   logic [UW-1:0] uo_q, uo_d;

   logic [KW-1:0] k_enc;
   logic [TW-1:0] t_val;
   logic [TW-1:0] diff;
   logic          ge;
   logic [UW-1:0] quo_next;

   assign oBusy = busy_q;
   assign oDone = done_q;
   assign oErr  = err_q;
   assign oK    = ko_q;
   assign oU    = uo_q;

   // Priority encoder: K = index of the most significant set bit + 1
   always_comb begin
      k_enc = '0;
      for (int i = 0; i < int'(MW); i++) begin
         if (m_q[i]) k_enc = KW'(i + 1);
      end
   end

   // One restoring step: shift in the dividend bit (a single leading 1), compare, subtract.
   // The remainder stays below M, so it fits in 32 bits between steps.
   always_comb begin
      t_val    = {rem_q, first_q};
      ge       = (t_val >= {1'b0, m_q});
      diff     = t_val - {1'b0, m_q};
      quo_next = UW'({quo_q, ge});
   end

   // Next-state and output logic
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      k_d     = k_q;
      first_d = first_q;
      zwait_d = zwait_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      ko_d    = ko_q;
      uo_d    = uo_q;

      case (state_q)
         S_IDLE: begin
            if (iStart) begin
               m_d     = iMod;
               zwait_d = 1'b0;
               busy_d  = 1'b1;
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            if (m_q == '0) begin
               // Zero modulus spends one extra NORM cycle so the error lands two cycles after acceptance
               if (zwait_q) begin
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  ko_d    = '0;
                  uo_d    = '0;
                  state_d = S_DONE;
               end else begin
                  zwait_d = 1'b1;
               end
            end else begin
               k_d     = k_enc;
               rem_d   = '0;
               quo_d   = '0;
               cnt_d   = CW'({k_enc, 1'b0}) + CW'(1);
               first_d = 1'b1;
               state_d = S_DIV;
            end
         end
         S_DIV: begin
            rem_d   = ge ? MW'(diff) : MW'(t_val);
            quo_d   = quo_next;
            first_d = 1'b0;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               done_d  = 1'b1;
               err_d   = 1'b0;
               ko_d    = k_q;
               uo_d    = quo_next;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous abort
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         k_q     <= '0;
         first_q <= 1'b0;
         zwait_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ko_q    <= '0;
         uo_q    <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         k_q     <= k_d;
         first_q <= first_d;
         zwait_q <= zwait_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ko_q    <= ko_d;
         uo_q    <= uo_d;
      end
   end

endmodule

// File: tb/tb_mod_barrett_param_gen_32b.sv
// Self-checking bench for mod_barrett_param_gen_32b: directed test-plan cases,
// busy/abort handling and a random sweep against an arithmetic reference.
module tb_mod_barrett_param_gen_32b;

   logic        iClk;
   logic        iRstN;
   logic        iStart;
   logic [31:0] iMod;
   logic        oBusy;
   logic        oDone;
   logic        oErr;
   logic [5:0]  oK;
   logic [63:0] oU;

   int checks = 0;
   int errors = 0;

   mod_barrett_param_gen_32b dut (
      .iClk   (iClk),
      .iRstN  (iRstN),
      .iStart (iStart),
      .iMod   (iMod),
      .oBusy  (oBusy),
      .oDone  (oDone),
      .oErr   (oErr),
      .oK     (oK),
      .oU     (oU)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // Compare and count
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: K = bit length, U = floor(2^(2K)/M), latency in cycles
   task automatic ref_model(input logic [31:0] m, output int k, output logic [63:0] u,
                            output int lat);
      logic [127:0] num;
      k = 0;
      for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
      num = 128'd1 << (2 * k);
      if (m == 32'd0) begin
         u   = 64'd0;
         lat = 2;
      end else begin
         u   = 64'(num / {96'd0, m});
         lat = 2 * k + 2;
      end
   endtask

   // Issue one request and check result, latency, busy and output hold
   task automatic run(input logic [31:0] m, output logic [5:0] got_k, output logic [63:0] got_u);
      int          k_exp;
      logic [63:0] u_exp;
      int          lat_exp;
      int          n;
      logic        seen;
      logic        held;
      logic [5:0]  k_prev;
      logic [63:0] u_prev;
      ref_model(m, k_exp, u_exp, lat_exp);
      k_prev = oK;
      u_prev = oU;
      held   = 1'b1;
      @(negedge iClk);
      iMod   = m;
      iStart = 1'b1;
      @(posedge iClk);
      #1;
      iStart = 1'b0;
      iMod   = $urandom;
      chk("busy_rise", 64'(oBusy), 64'd1);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 100) begin
         @(posedge iClk);
         #1;
         n++;
         if (oDone) seen = 1'b1;
         else if (oK !== k_prev || oU !== u_prev) held = 1'b0;
      end
      got_k = oK;
      got_u = oU;
      chk("done_seen", 64'(seen), 64'd1);
      chk("latency", 64'(n), 64'(lat_exp));
      chk("k", 64'(oK), 64'(k_exp));
      chk("u", oU, u_exp);
      chk("err", 64'(oErr), (m == 32'd0) ? 64'd1 : 64'd0);
      chk("hold", 64'(held), 64'd1);
      @(posedge iClk);
      #1;
      chk("done_pulse", 64'(oDone), 64'd0);
      chk("busy_fall", 64'(oBusy), 64'd0);
   endtask

   initial begin
      logic [5:0]  rk;
      logic [63:0] ru;
      int          dones;
      logic [5:0]  bk;
      logic [63:0] bu;
      logic [31:0] rm;

      iRstN  = 1'b0;
      iStart = 1'b0;
      iMod   = 32'd0;
      repeat (3) @(posedge iClk);
      #1;
      chk("rst_busy", 64'(oBusy), 64'd0);
      chk("rst_done", 64'(oDone), 64'd0);
      chk("rst_err", 64'(oErr), 64'd0);
      chk("rst_k", 64'(oK), 64'd0);
      chk("rst_u", oU, 64'd0);
      @(negedge iClk);
      iRstN = 1'b1;

      // Directed cases with literal expectations
      run(32'hFFFF_FFFF, rk, ru);
      chk("ffff_k", 64'(rk), 64'd32);
      chk("ffff_u", ru, 64'h0000_0001_0000_0001);
      run(32'd7681, rk, ru);
      chk("7681_k", 64'(rk), 64'd13);
      chk("7681_u", ru, 64'd8736);
      run(32'd1, rk, ru);
      chk("one_k", 64'(rk), 64'd1);
      chk("one_u", ru, 64'd4);
      run(32'h8000_0000, rk, ru);
      chk("msb_k", 64'(rk), 64'd32);
      chk("msb_u", ru, 64'h0000_0002_0000_0000);
      run(32'd0, rk, ru);
      chk("zero_k", 64'(rk), 64'd0);
      chk("zero_u", ru, 64'd0);

      // Requests while busy are dropped; exactly one result for the accepted modulus
      @(negedge iClk);
      iMod   = 32'd7681;
      iStart = 1'b1;
      @(posedge iClk);
      #1;
      iStart = 1'b0;
      dones  = 0;
      bk     = '0;
      bu     = '0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 5) begin
            iStart = 1'b1;
            iMod   = 32'd3;
         end else if (c == 6) begin
            iStart = 1'b0;
            iMod   = 32'h1234_5678;
         end
         @(posedge iClk);
         #1;
         if (oDone) begin
            dones++;
            bk = oK;
            bu = oU;
         end
      end
      chk("busy_dones", 64'(dones), 64'd1);
      chk("busy_k", 64'(bk), 64'd13);
      chk("busy_u", bu, 64'd8736);

      // Asynchronous abort mid-divide
      @(negedge iClk);
      iMod   = 32'd7681;
      iStart = 1'b1;
      @(posedge iClk);
      #1;
      iStart = 1'b0;
      repeat (10) @(posedge iClk);
      #3;
      iRstN = 1'b0;
      #1;
      chk("abort_busy", 64'(oBusy), 64'd0);
      chk("abort_done", 64'(oDone), 64'd0);
      chk("abort_err", 64'(oErr), 64'd0);
      chk("abort_k", 64'(oK), 64'd0);
      chk("abort_u", oU, 64'd0);
      repeat (2) @(posedge iClk);
      @(negedge iClk);
      iRstN = 1'b1;
      dones = 0;
      repeat (30) begin
         @(posedge iClk);
         #1;
         if (oDone) dones++;
      end
      chk("abort_nodone", 64'(dones), 64'd0);
      run(32'd3, rk, ru);
      chk("three_k", 64'(rk), 64'd2);
      chk("three_u", ru, 64'd5);

      // Random sweep over all bit lengths
      for (int r = 0; r < 200; r++) begin
         rm = $urandom;
         rm = rm >> $urandom_range(0, 31);
         run(rm, rk, ru);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
